// File: rtl/word_packer_if.sv
// Byte-in / word-out bus of the word packer.
// The upstream byte stream and the downstream async-FIFO write port share one bundle.
// The slave side is the packer; the master side is whatever drives bytes and owns the FIFO.
interface word_packer_if;
  // upstream byte stream
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;

  // downstream FIFO write port
  logic [15:0] fifo_data;
  logic        fifo_wr_en;
  logic        fifo_full;

  // status
  logic        frame_done;
  logic [15:0] word_count;

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output fifo_data,
    output fifo_wr_en,
    input  fifo_full,
    output frame_done,
    output word_count
  );

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  fifo_data,
    input  fifo_wr_en,
    output fifo_full,
    input  frame_done,
    input  word_count
  );
endinterface

// File: rtl/word_packer.sv
// Packs an 8-bit byte stream into 16-bit words, low byte first, for a
// downstream async FIFO.
// A frame that ends on a low byte is closed with PAD_BYTE as its high byte.
// A single holding register with a pending flag feeds the FIFO. It can be
// written out and reloaded on the same edge, so a continuous stream runs at
// one word every two byte cycles with no bubble.
module word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         wr_clk,
  input  logic         wr_reset,
  word_packer_if.slave bus
);

  typedef enum logic {
    ST_LOW  = 1'b0,  // waiting for the low byte of a word
    ST_HIGH = 1'b1   // low byte captured, waiting for the high byte
  } state_t;

  state_t      state_reg;
  logic [7:0]  low_byte_reg;
  logic [15:0] hold_reg;
  logic        pending_reg;
  logic        last_word_reg;
  logic        frame_done_reg;
  logic [15:0] word_count_reg;

  logic        byte_accept;
  logic        word_write;
  logic        word_load;
  logic [15:0] load_word;

  // A full FIFO only stalls us when a word is actually waiting to go out.
  assign bus.in_ready = !pending_reg || !bus.fifo_full;
  assign byte_accept  = bus.in_valid && bus.in_ready;
  assign word_write   = pending_reg && !bus.fifo_full;

  // A word completes on the high byte, or early when the frame ends on a low byte.
  assign word_load    = byte_accept && ((state_reg == ST_HIGH) || bus.in_last);

  // Build each byte lane of the word being loaded.
  // Lane 0 holds the captured low byte in HIGH, otherwise the incoming byte.
  // Lane 1 holds the incoming byte in HIGH, otherwise the pad byte.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    if (gi == 0) begin : g_low
      assign load_word[gi*8 +: 8] = (state_reg == ST_HIGH) ? low_byte_reg : bus.in_data;
    end else begin : g_high
      assign load_word[gi*8 +: 8] = (state_reg == ST_HIGH) ? bus.in_data : PAD_BYTE;
    end
  end

  // Assembly FSM together with the output holding register, frame marker and word counter.
  always_ff @(posedge wr_clk or posedge wr_reset) begin
    if (wr_reset) begin
      state_reg      <= ST_LOW;
      low_byte_reg   <= 8'h00;
      hold_reg       <= 16'h0000;
      pending_reg    <= 1'b0;
      last_word_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      word_count_reg <= 16'h0000;
    end else begin
      // Every word leaving for the FIFO is counted; the counter wraps naturally.
      if (word_write) begin
        word_count_reg <= word_count_reg + 16'd1;
      end

      // Pulse one cycle after the closing word of a frame is written.
      frame_done_reg <= word_write && last_word_reg;

      // A reload takes priority over clearing, so write plus reload keeps pending set.
      if (word_load) begin
        hold_reg      <= load_word;
        pending_reg   <= 1'b1;
        last_word_reg <= bus.in_last;
      end else if (word_write) begin
        pending_reg   <= 1'b0;
      end

      // Byte assembly.
      // A lone last byte in LOW is padded out and leaves us in LOW.
      if (byte_accept) begin
        if (state_reg == ST_LOW) begin
          if (!bus.in_last) begin
            low_byte_reg <= bus.in_data;
            state_reg    <= ST_HIGH;
          end
        end else begin
          state_reg <= ST_LOW;
        end
      end
    end
  end

  assign bus.fifo_data  = hold_reg;
  assign bus.fifo_wr_en = pending_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.word_count = word_count_reg;

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 The block SHALL have parameter PAD_BYTE, default 8'h00, the byte used as the high byte when a frame ends on a low byte.
REQ-002 The block SHALL have port wr_clk, input, 1 bit: the write-domain clock; all logic is rising-edge.
REQ-003 The block SHALL have port wr_reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_data, input, 8 bits: upstream byte.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_last, input, 1 bit: the current byte is the final byte of its frame.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 The block SHALL have port fifo_data, output, 16 bits: packed word, low byte first.
REQ-009 The block SHALL have port fifo_wr_en, output, 1 bit: write request to the downstream async FIFO.
REQ-010 The block SHALL have port fifo_full, input, 1 bit: the downstream FIFO full flag.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last word of a frame is written.
REQ-012 The block SHALL have port word_count, output, 16 bits: words written since reset; wraps modulo 2^16.

Function
REQ-013 The block SHALL define a byte as accepted on a rising edge where in_valid && in_ready.
REQ-014 The block SHALL define a word as written on a rising edge where fifo_wr_en && !fifo_full.
REQ-015 The block SHALL implement an assembly state machine with two states: LOW (expecting the low byte) and HIGH (holding the low byte, expecting the high byte).
REQ-016 The block SHALL implement an output holding register with a pending flag; fifo_wr_en SHALL equal the pending flag, and fifo_data SHALL be the holding register.
REQ-017 in_ready SHALL be combinational: !pending || !fifo_full.
REQ-018 In LOW, an accepted byte with in_last=0 SHALL be stored as the low byte, and the state SHALL move to HIGH.
REQ-019 In LOW, an accepted byte with in_last=1 SHALL load the holding register with {PAD_BYTE, in_data}, set pending and a last-word marker, and keep the state at LOW.
REQ-020 In HIGH, an accepted byte SHALL load the holding register with {in_data, low byte}, set pending, and return the state to LOW; the last-word marker SHALL equal in_last.
REQ-021 Latency SHALL be as follows: a word-completing byte accepted at edge N gives fifo_wr_en=1 with valid fifo_data from edge N to edge N+1.
REQ-022 While pending && fifo_full, fifo_wr_en and fifo_data SHALL hold stable, and no byte SHALL be accepted.
REQ-023 A write and the load of a new word on the same edge SHALL be allowed, so that sustained throughput is 1 word per 2 byte-cycles with no bubble.
REQ-024 On a write with no same-edge reload, pending SHALL clear.
REQ-025 On every write, word_count SHALL increment by 1; 16'hFFFF SHALL wrap to 0.
REQ-026 frame_done SHALL be registered and SHALL be high the cycle after a write whose last-word marker is set.
REQ-027 in_last while in HIGH SHALL close the frame on that word (even byte count), and no pad SHALL be inserted.
REQ-028 Bytes with in_valid=0 SHALL NOT change state, regardless of in_last.
REQ-029 Frame boundaries SHALL NOT be otherwise encoded in fifo_data.

Reset
REQ-030 On wr_reset assertion, the block SHALL asynchronously set state=LOW, pending=0, fifo_wr_en=0, fifo_data=0, frame_done=0, word_count=0, and clear the low byte and last-word marker.
REQ-031 A reset mid-word or with a word pending SHALL discard the partial or pending word; no write SHALL occur after reset until new bytes are accepted.
REQ-032 in_ready SHALL be 1 during and immediately after reset (pending=0).

Verification
REQ-033 The bench SHALL cover: bytes 11,22,33,44 (last on 44), fifo_full=0 -> words 16'h2211, 16'h4433 written on consecutive word slots; frame_done once, after 16'h4433; word_count=2.
REQ-034 The bench SHALL cover: bytes AA,BB,CC with last on CC, PAD_BYTE=00 -> words 16'hBBAA, 16'h00CC; frame_done after 16'h00CC.
REQ-035 The bench SHALL cover: word 16'h2211 pending with fifo_full held high for 5 cycles -> fifo_wr_en high and fifo_data stable for all 5, in_ready=0, and exactly one write when full drops.
REQ-036 The bench SHALL cover: continuous valid bytes with fifo_full=0 -> in_ready never drops, and fifo_wr_en pulses every second cycle.
REQ-037 The bench SHALL cover: reset asserted after byte 55 is accepted in HIGH -> next bytes 66,77 produce 16'h7766, not 16'h6655, and word_count restarts at 0.
REQ-038 The bench SHALL cover: word_count preloaded via 65535 writes, then one more write -> word_count=0.
